// File: rtl/axis_frame_tlast_packer_pkg.sv
// axis_frame_tlast_packer_pkg: default geometry and counter sizing shared by the packer and its FIFO
package axis_frame_tlast_packer_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_WORDS_PER_LINE  = 50;
    localparam int DEF_LINES_PER_FRAME = 200;
    localparam int DEF_FIFO_DEPTH      = 16;
    localparam int DEF_NB_FRAME_CNT    = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_frame_tlast_packer_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers; head reads as zero when empty
module axis_sync_fifo
    import axis_frame_tlast_packer_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 2,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance: full/empty come from the registered pointers, so a write while full is refused even if a read frees a slot this cycle
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Storage array, no reset needed since the head is masked while empty
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/axis_frame_tlast_packer.sv
// axis_frame_tlast_packer: buffers convolver words, tags frame start (tuser) and line end (tlast), drops on overflow
module axis_frame_tlast_packer
    import axis_frame_tlast_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int NB_FRAME_CNT    = DEF_NB_FRAME_CNT
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic                    s_axis_valid,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    s_axis_ready,
    output logic                    m_axis_valid,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic                    m_axis_last,
    output logic                    m_axis_user,
    input  logic                    m_axis_ready,
    output logic                    o_overflow,
    output logic [NB_FRAME_CNT-1:0] o_frame_count
);

    localparam int WW = cnt_w(WORDS_PER_LINE);
    localparam int LW = cnt_w(LINES_PER_FRAME);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [WW-1:0] W_MAX = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] L_MAX = LW'(LINES_PER_FRAME - 1);

    logic [WW-1:0]           word_cnt_q, word_cnt_d;
    logic [LW-1:0]           line_cnt_q, line_cnt_d;
    logic [LW-1:0]           out_line_q, out_line_d, cur_line;
    logic                    overflow_q, overflow_d;
    logic [NB_FRAME_CNT-1:0] frame_cnt_q, frame_cnt_d;
    logic                    full, empty, pop, in_user, in_last;
    logic [EW-1:0]           rd_entry;

    assign in_user = (word_cnt_q == '0) && (line_cnt_q == '0);
    assign in_last = word_cnt_q == W_MAX;
    assign pop     = m_axis_valid && m_axis_ready;

    axis_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (axi_clk),
        .rst_ni    (axi_reset_n),
        .wr_en_i   (s_axis_valid),
        .wr_data_i ({in_user, in_last, s_axis_data}),
        .rd_en_i   (pop),
        .rd_data_o (rd_entry),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign {m_axis_user, m_axis_last, m_axis_data} = rd_entry;
    assign m_axis_valid  = !empty;
    assign s_axis_ready  = !full;
    assign o_overflow    = overflow_q;
    assign o_frame_count = frame_cnt_q;

    // Input framing: counts every valid word, written or dropped, so tags stay aligned to the source
    always_comb begin
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        if (s_axis_valid) begin
            word_cnt_d = in_last ? '0 : word_cnt_q + 1'b1;
            if (in_last) line_cnt_d = (line_cnt_q == L_MAX) ? '0 : line_cnt_q + 1'b1;
        end
        overflow_d = overflow_q || (s_axis_valid && full);
    end

    // Output framing: a user pop restarts the line count; last on the final line closes a frame
    always_comb begin
        cur_line    = m_axis_user ? '0 : out_line_q;
        out_line_d  = out_line_q;
        frame_cnt_d = frame_cnt_q;
        if (pop) begin
            out_line_d = cur_line;
            if (m_axis_last) begin
                out_line_d  = (cur_line == L_MAX) ? '0 : cur_line + 1'b1;
                frame_cnt_d = (cur_line == L_MAX) ? frame_cnt_q + 1'b1 : frame_cnt_q;
            end
        end
    end

    // Framing counters, sticky overflow and frame count registers
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            out_line_q  <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            out_line_q  <= out_line_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_tlast_packer.sv
// tb_axis_frame_tlast_packer: scoreboard bench for a full-size packer and a 2x2-frame packer
module tb_axis_frame_tlast_packer;

    typedef struct packed {
        logic        user;
        logic        last;
        logic        eof;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic        m_last [2];
    logic        m_user [2];
    logic        ovf [2];
    logic [31:0] s_data [2];
    logic [31:0] m_data [2];
    logic [15:0] fc_a;
    logic [1:0]  fc_b;

    int   n_chk = 0;
    int   n_pass = 0;
    int   wpl [2]  = '{50, 2};
    int   lpf [2]  = '{200, 2};
    int   dep [2]  = '{16, 4};
    int   fmod [2] = '{65536, 4};
    int   wm [2];
    int   lm [2];
    int   exp_fc [2];
    int   npop [2];
    bit   exp_ovf [2];
    bit   rnd_b = 1'b0;
    int   next_b = 1000;
    ent_t sb0 [$];
    ent_t sb1 [$];

    always #5 clk = ~clk;

    axis_frame_tlast_packer dut_a (
        .axi_clk       (clk),
        .axi_reset_n   (rst_n[0]),
        .s_axis_valid  (s_valid[0]),
        .s_axis_data   (s_data[0]),
        .s_axis_ready  (s_ready[0]),
        .m_axis_valid  (m_valid[0]),
        .m_axis_data   (m_data[0]),
        .m_axis_last   (m_last[0]),
        .m_axis_user   (m_user[0]),
        .m_axis_ready  (m_ready[0]),
        .o_overflow    (ovf[0]),
        .o_frame_count (fc_a)
    );

    axis_frame_tlast_packer #(
        .WORDS_PER_LINE  (2),
        .LINES_PER_FRAME (2),
        .FIFO_DEPTH      (4),
        .NB_FRAME_CNT    (2)
    ) dut_b (
        .axi_clk       (clk),
        .axi_reset_n   (rst_n[1]),
        .s_axis_valid  (s_valid[1]),
        .s_axis_data   (s_data[1]),
        .s_axis_ready  (s_ready[1]),
        .m_axis_valid  (m_valid[1]),
        .m_axis_data   (m_data[1]),
        .m_axis_last   (m_last[1]),
        .m_axis_user   (m_user[1]),
        .m_axis_ready  (m_ready[1]),
        .o_overflow    (ovf[1]),
        .o_frame_count (fc_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sb_size(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic ent_t sb_front(input int k);
        return (k == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int k, input ent_t e);
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic sb_pop(input int k);
        if (k == 0) void'(sb0.pop_front());
        else void'(sb1.pop_front());
    endtask

    function automatic logic [63:0] fc_of(input int k);
        return (k == 0) ? 64'(fc_a) : 64'(fc_b);
    endfunction

    task automatic step(input int k, input bit v, input logic [31:0] d);
        ent_t e;
        chk("s_ready", 64'(s_ready[k]), 64'(sb_size(k) < dep[k]));
        chk("overflow", 64'(ovf[k]), 64'(exp_ovf[k]));
        chk("frame_count", fc_of(k), 64'(exp_fc[k]));
        s_valid[k] = v;
        s_data[k]  = d;
        if (k == 1 && rnd_b) m_ready[1] = 1'($urandom_range(0, 1));
        if (v) begin
            e.user = (wm[k] == 0) && (lm[k] == 0);
            e.last = wm[k] == wpl[k] - 1;
            e.eof  = e.last && (lm[k] == lpf[k] - 1);
            e.data = d;
            if (sb_size(k) < dep[k]) sb_push(k, e);
            else exp_ovf[k] = 1'b1;
            if (e.last) begin
                wm[k] = 0;
                lm[k] = e.eof ? 0 : lm[k] + 1;
            end else wm[k]++;
        end
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int budget);
        for (int c = 0; c < budget && sb_size(k) > 0; c++) step(k, 1'b0, 32'h0);
        chk("drain_left", 64'(sb_size(k)), 64'(0));
    endtask

    task automatic do_reset(input int k);
        rst_n[k]   = 1'b0;
        s_valid[k] = 1'b0;
        if (k == 0) sb0.delete();
        else sb1.delete();
        wm[k]      = 0;
        lm[k]      = 0;
        exp_ovf[k] = 1'b0;
        exp_fc[k]  = 0;
        @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid[k]), 64'(0));
        chk("rst_m_data", 64'(m_data[k]), 64'(0));
        chk("rst_m_last", 64'(m_last[k]), 64'(0));
        chk("rst_m_user", 64'(m_user[k]), 64'(0));
        chk("rst_s_ready", 64'(s_ready[k]), 64'(1));
        chk("rst_overflow", 64'(ovf[k]), 64'(0));
        chk("rst_frame_count", fc_of(k), 64'(0));
        rst_n[k] = 1'b1;
    endtask

    task automatic send_b(input int n);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 50 && (sb1.size() >= 4 || $urandom_range(0, 2) == 0); g++)
                step(1, 1'b0, 32'h0);
            step(1, 1'b1, 32'(next_b));
            next_b++;
        end
    endtask

    // Scoreboard: every presented word must match the queue head; it leaves the queue only when accepted
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k] && m_valid[k]) begin
                if (sb_size(k) == 0) chk("spurious_valid", 64'(m_valid[k]), 64'(0));
                else begin
                    ent_t e;
                    e = sb_front(k);
                    chk("m_data", 64'(m_data[k]), 64'(e.data));
                    chk("m_last", 64'(m_last[k]), 64'(e.last));
                    chk("m_user", 64'(m_user[k]), 64'(e.user));
                    if (m_ready[k]) begin
                        sb_pop(k);
                        npop[k]++;
                        if (e.eof) exp_fc[k] = (exp_fc[k] + 1) % fmod[k];
                    end
                end
            end
        end
    end

    initial begin
        int i;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]   = 1'b0;
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b0;
            npop[k]    = 0;
        end
        do_reset(0);
        do_reset(1);

        // one full frame, index as data, no backpressure
        m_ready[0] = 1'b1;
        for (int n = 0; n < 10000; n++) step(0, 1'b1, 32'(n));
        drain(0, 64);
        chk("t1_words", 64'(npop[0]), 64'(10000));
        chk("t1_frames", 64'(fc_a), 64'(1));
        chk("t1_overflow", 64'(ovf[0]), 64'(0));

        // backpressure: 16 stored, 4 dropped
        npop[0]    = 0;
        m_ready[0] = 1'b0;
        for (int n = 0; n < 20; n++) step(0, 1'b1, 32'(n));
        chk("t2_ready_low", 64'(s_ready[0]), 64'(0));
        chk("t2_overflow", 64'(ovf[0]), 64'(1));
        chk("t2_head", 64'(m_data[0]), 64'(0));

        // push and pop together while full: push dropped, occupancy 15
        m_ready[0] = 1'b1;
        step(0, 1'b1, 32'd20);
        chk("t3_ready_back", 64'(s_ready[0]), 64'(1));
        for (int n = 21; n < 60; n++) step(0, 1'b1, 32'(n));
        drain(0, 64);
        chk("t23_words", 64'(npop[0]), 64'(55));

        // reset mid line 7 with 5 words buffered
        i = 60;
        while (!(lm[0] == 7 && wm[0] == 3)) begin
            step(0, 1'b1, 32'(i));
            i++;
        end
        drain(0, 64);
        m_ready[0] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step(0, 1'b1, 32'(i));
            i++;
        end
        chk("t5_valid_before", 64'(m_valid[0]), 64'(1));
        chk("t5_overflow_before", 64'(ovf[0]), 64'(1));
        chk("t5_frames_before", 64'(fc_a), 64'(1));
        do_reset(0);
        npop[0]    = 0;
        m_ready[0] = 1'b1;
        step(0, 1'b1, 32'hCAFE0000);
        drain(0, 64);
        chk("t5_words", 64'(npop[0]), 64'(1));

        // small frame: random backpressure, 3 frames, then wrap of the 2-bit frame count
        rnd_b = 1'b1;
        send_b(12);
        drain(1, 400);
        chk("t4_frames", 64'(fc_b), 64'(3));
        chk("t4_overflow", 64'(ovf[1]), 64'(0));
        chk("t4_words", 64'(npop[1]), 64'(12));
        send_b(8);
        drain(1, 400);
        chk("t6_wrap", 64'(fc_b), 64'(1));
        chk("t6_overflow", 64'(ovf[1]), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
